// File: rtl/operand_sel_pkg.sv
// Shared types and defaults for the operand select pipeline.
// Contents: output-stage FSM state type, mode encodings, default sizes.
package operand_sel_pkg;

  localparam int unsigned DEF_WORD_WIDTH = 16;
  localparam int unsigned DEF_NUM_IN     = 4;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mux_n_to_1.sv
// Combinational NUM_IN-way word selector; out-of-range indices give zero.
// Ports:
//   in_data    : flat input bus, channel k at [k*WORD_WIDTH +: WORD_WIDTH]
//   idx        : channel index
//   sel_data_c : selected word (combinational)
module mux_n_to_1
  import operand_sel_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned NUM_IN     = DEF_NUM_IN,
  parameter int unsigned SEL_WIDTH  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WORD_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]         idx,
  output logic [WORD_WIDTH-1:0]        sel_data_c
);

  // Indices with no matching channel fall through to the zero default.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (idx == SEL_WIDTH'(k)) begin
        sel_data_c = in_data[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

endmodule

// File: rtl/operand_sel_pipe.sv
// One-stage valid/ready pipeline selecting one of NUM_IN words, either by an
// explicit index (mode 0) or by a round-robin sweep pointer (mode 1).
// Optional feature: define OPERAND_SEL_SKID_EN to add a one-entry skid
// register so in_ready no longer depends combinationally on out_ready.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   mode, sel, in_data  : selection control and flat input word bus
//   in_valid, in_ready  : input handshake
//   out_data, out_idx   : selected word and its channel index
//   out_valid, out_ready: output handshake
//   sweep_done          : word came from channel NUM_IN-1 in round-robin mode
module operand_sel_pipe
  import operand_sel_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned NUM_IN     = DEF_NUM_IN,
  parameter int unsigned SEL_WIDTH  = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic [NUM_IN*WORD_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WORD_WIDTH-1:0]        out_data,
  output logic [SEL_WIDTH-1:0]         out_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         sweep_done
);

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_IN - 1);

  state_t                 state;
  logic [SEL_WIDTH-1:0]   rr_ptr;
  logic [SEL_WIDTH-1:0]   idx_c;
  logic [WORD_WIDTH-1:0]  mux_data_c;
  logic                   done_c;
  logic                   in_xfer_c;
  logic                   out_xfer_c;

  assign idx_c      = (mode == MODE_RR) ? rr_ptr : sel;
  assign done_c     = (mode == MODE_RR) && (idx_c == LAST_IDX);
  assign in_xfer_c  = in_valid && in_ready;
  assign out_xfer_c = out_valid && out_ready;

  mux_n_to_1 #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_IN     (NUM_IN),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_mux (
    .in_data    (in_data),
    .idx        (idx_c),
    .sel_data_c (mux_data_c)
  );

  // Sweep pointer: steps on round-robin transfers, restarts on explicit ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (in_xfer_c) begin
      if (mode == MODE_SEL || rr_ptr == LAST_IDX) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= rr_ptr + SEL_WIDTH'(1);
      end
    end
  end

`ifdef OPERAND_SEL_SKID_EN

  logic                  skid_valid;
  logic [WORD_WIDTH-1:0] skid_data;
  logic [SEL_WIDTH-1:0]  skid_idx;
  logic                  skid_done;

  // Ready depends only on skid occupancy, never on out_ready.
  assign in_ready = rst_n && !skid_valid;

  // Output stage; a word accepted while stalled parks in the skid entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      sweep_done <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_idx   <= '0;
      skid_done  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer_c) begin
            state      <= FULL;
            out_valid  <= 1'b1;
            out_data   <= mux_data_c;
            out_idx    <= idx_c;
            sweep_done <= done_c;
          end
        end
        FULL: begin
          if (skid_valid) begin
            if (out_xfer_c) begin
              out_data   <= skid_data;
              out_idx    <= skid_idx;
              sweep_done <= skid_done;
              skid_valid <= 1'b0;
            end
          end else if (in_xfer_c) begin
            if (out_xfer_c) begin
              out_data   <= mux_data_c;
              out_idx    <= idx_c;
              sweep_done <= done_c;
            end else begin
              skid_valid <= 1'b1;
              skid_data  <= mux_data_c;
              skid_idx   <= idx_c;
              skid_done  <= done_c;
            end
          end else if (out_xfer_c) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

`else

  // Accept whenever the output register is free or is being drained.
  assign in_ready = rst_n && ((state == EMPTY) || out_ready);

  // Output stage: single holding register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      sweep_done <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer_c) begin
            state      <= FULL;
            out_valid  <= 1'b1;
            out_data   <= mux_data_c;
            out_idx    <= idx_c;
            sweep_done <= done_c;
          end
        end
        FULL: begin
          if (in_xfer_c) begin
            out_data   <= mux_data_c;
            out_idx    <= idx_c;
            sweep_done <= done_c;
          end else if (out_xfer_c) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Self-checking bench for operand_sel_pipe: directed vectors on a 4-channel
// and a 3-channel instance, then random valid/ready traffic with a scoreboard.
// Honours OPERAND_SEL_SKID_EN for the expected in_ready during stalls.
module tb_operand_sel_pipe;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned IW = W + SW + 1;

`ifdef OPERAND_SEL_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode;
  logic [SW-1:0] sel;
  logic [N*W-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_idx;
  logic          out_valid;
  logic          out_ready;
  logic          sweep_done;

  logic [3*W-1:0] in_data3;
  logic          in_ready3;
  logic [W-1:0]  out_data3;
  logic [SW-1:0] out_idx3;
  logic          out_valid3;
  logic          sweep_done3;

  assign in_data3 = in_data[3*W-1:0];

  always #5 clk = ~clk;

  operand_sel_pipe #(.WORD_WIDTH(W), .NUM_IN(N), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .sweep_done(sweep_done)
  );

  operand_sel_pipe #(.WORD_WIDTH(W), .NUM_IN(3), .SEL_WIDTH(SW)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data3),
    .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
    .out_idx(out_idx3), .out_valid(out_valid3), .out_ready(out_ready),
    .sweep_done(sweep_done3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [N*W-1:0] CHANS = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  localparam logic [4*W-1:0] CH_TBL = CHANS;

  logic [IW-1:0] sb_q[$];
  logic [IW-1:0] exp_item;
  logic [SW-1:0] rr_model;
  logic [SW-1:0] m_idx;
  logic [W-1:0]  m_data;
  logic [4*W-1:0] ch_tbl;

  initial begin
    ch_tbl    = CH_TBL;
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = CHANS;
    tick();
    tick();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_sweep_done", 32'(sweep_done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("empty_in_ready", 32'(in_ready), 32'd1);

    // Explicit select, sel=2
    sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("sel2_valid", 32'(out_valid), 32'd1);
    check("sel2_data", 32'(out_data), 32'h3333);
    check("sel2_idx", 32'(out_idx), 32'd2);
    check("sel2_sweep", 32'(sweep_done), 32'd0);
    check("n3_sel2_data", 32'(out_data3), 32'h3333);
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);

    // sel=3: in range for 4 channels, out of range for 3
    sel = 2'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("sel3_data", 32'(out_data), 32'h4444);
    check("sel3_idx", 32'(out_idx), 32'd3);
    check("sel3_sweep_mode0", 32'(sweep_done), 32'd0);
    check("n3_oob_data", 32'(out_data3), 32'd0);
    check("n3_oob_idx", 32'(out_idx3), 32'd3);
    tick();

    // Round-robin sweep, 6 back-to-back words
    mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rr_idx_%0d", i), 32'(out_idx), 32'(i % 4));
      check($sformatf("rr_data_%0d", i), 32'(out_data), 32'(ch_tbl[(i%4)*W +: W]));
      check($sformatf("rr_sweep_%0d", i), 32'(sweep_done), 32'((i % 4) == 3));
      check($sformatf("n3_rr_idx_%0d", i), 32'(out_idx3), 32'(i % 3));
      check($sformatf("n3_rr_sweep_%0d", i), 32'(sweep_done3), 32'((i % 3) == 2));
    end

    // Reset while FULL with rr_ptr=2
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("postrst_valid", 32'(out_valid), 32'd1);
    check("postrst_idx", 32'(out_idx), 32'd0);
    check("postrst_data", 32'(out_data), 32'h1111);
    tick();

    // Stall for 3 cycles with a pending input word
    mode = 1'b0; sel = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; sel = 2'd1;
    #1;
    check("stall_first_ready", 32'(in_ready), 32'(SKID));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_data_%0d", i), 32'(out_data), 32'h1111);
      check($sformatf("stall_idx_%0d", i), 32'(out_idx), 32'd0);
      check($sformatf("stall_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("stall_ready_%0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("release_data", 32'(out_data), 32'h2222);
    check("release_idx", 32'(out_idx), 32'd1);
    check("release_valid", 32'(out_valid), 32'd1);
    tick();
    check("release_empty", 32'(out_valid), 32'd0);

    // Random traffic against a scoreboard
    rr_model = '0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, 3));
      in_data   = {$urandom(), $urandom()};
      @(negedge clk);
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp_item = sb_q.pop_front();
          check("sb_item", 32'({out_data, out_idx, sweep_done}), 32'(exp_item));
        end
      end
      if (in_valid && in_ready) begin
        m_idx  = mode ? rr_model : sel;
        m_data = in_data[m_idx*W +: W];
        sb_q.push_back({m_data, m_idx, mode && (m_idx == SW'(N - 1))});
        rr_model = (!mode || rr_model == SW'(N - 1)) ? '0 : rr_model + SW'(1);
      end
      @(posedge clk);
      #1;
    end

    // Drain with a bounded wait
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8 && sb_q.size() != 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        exp_item = sb_q.pop_front();
        check("drain_item", 32'({out_data, out_idx, sweep_done}), 32'(exp_item));
      end
      @(posedge clk);
      #1;
    end
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("final_empty", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
